// File: rtl/seq_alu.sv
// Sequential integer ALU. Single-cycle ops finish one cycle after accept; multiply and divide
// run XLEN shift-add / restoring iterations on magnitudes, followed by one sign-fix cycle.
module seq_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] inp1,
  input  logic [XLEN-1:0] inp2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            out_illegal
);

  localparam int SW = $clog2(XLEN);
  localparam logic [SW-1:0] CNT_LAST = SW'(XLEN - 1);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_SLL    = 5'd4;
  localparam logic [4:0] OP_SRL    = 5'd5;
  localparam logic [4:0] OP_XOR    = 5'd6;
  localparam logic [4:0] OP_SLT    = 5'd7;
  localparam logic [4:0] OP_SLTU   = 5'd8;
  localparam logic [4:0] OP_SLA    = 5'd9;
  localparam logic [4:0] OP_SRA    = 5'd10;
  localparam logic [4:0] OP_MUL    = 5'd11;
  localparam logic [4:0] OP_MULH   = 5'd12;
  localparam logic [4:0] OP_MULHSU = 5'd13;
  localparam logic [4:0] OP_MULHU  = 5'd14;
  localparam logic [4:0] OP_DIV    = 5'd15;
  localparam logic [4:0] OP_DIVU   = 5'd16;
  localparam logic [4:0] OP_REM    = 5'd17;
  localparam logic [4:0] OP_REMU   = 5'd18;

  typedef enum logic [1:0] {IDLE, EXEC, FIX, DONE} state_t;

  state_t          state_q;
  logic [SW-1:0]   cnt_q;
  logic [4:0]      op_q;
  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic            qneg_q, rneg_q, dz_q;
  logic [XLEN-1:0] out_q;
  logic            ill_q;

  logic [XLEN-1:0] alu_res_d;
  logic            alu_ill_d;
  logic [SW-1:0]   shamt;
  logic            is_multi, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] hi_d, lo_d;
  logic [XLEN:0]   mul_sum, div_trial;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] fix_res_d;

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out         = out_q;
  assign out_illegal = ill_q;

  assign shamt = inp2[SW-1:0];

  always_comb begin
    alu_res_d = '0;
    alu_ill_d = 1'b0;
    case (op)
      OP_ADD:          alu_res_d = inp1 + inp2;
      OP_SUB:          alu_res_d = inp1 - inp2;
      OP_AND:          alu_res_d = inp1 & inp2;
      OP_OR:           alu_res_d = inp1 | inp2;
      OP_SLL, OP_SLA:  alu_res_d = inp1 << shamt;
      OP_SRL:          alu_res_d = inp1 >> shamt;
      OP_XOR:          alu_res_d = inp1 ^ inp2;
      OP_SLT:          alu_res_d = {{(XLEN-1){1'b0}}, $signed(inp1) < $signed(inp2)};
      OP_SLTU:         alu_res_d = {{(XLEN-1){1'b0}}, inp1 < inp2};
      OP_SRA:          alu_res_d = $unsigned($signed(inp1) >>> shamt);
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_res_d = '0;
      default:         alu_ill_d = 1'b1;
    endcase
  end

  // Operands are reduced to magnitudes at accept; signs are reapplied in FIX.
  assign is_multi = (op >= OP_MUL) && (op <= OP_REMU);
  assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign a_neg    = a_signed & inp1[XLEN-1];
  assign b_neg    = b_signed & inp2[XLEN-1];
  assign a_mag    = a_neg ? -inp1 : inp1;
  assign b_mag    = b_neg ? -inp2 : inp2;

  // One iteration: hi/lo hold accumulator/multiplier for MUL*, remainder/quotient for DIV*/REM*.
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
  assign div_trial = {hi_q, lo_q[XLEN-1]} - {1'b0, b_q};

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (op_q >= OP_DIV) begin
      if (!div_trial[XLEN]) begin
        hi_d = div_trial[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum[XLEN:1];
      lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  assign prod     = {hi_q, lo_q};
  assign prod_fix = qneg_q ? -prod : prod;

  always_comb begin
    fix_res_d = '0;
    case (op_q)
      OP_MUL:                        fix_res_d = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res_d = prod_fix[2*XLEN-1:XLEN];
      // A zero divisor yields all-ones magnitude; the signed quotient must not be negated.
      OP_DIV, OP_DIVU:               fix_res_d = dz_q ? '1 : (qneg_q ? -lo_q : lo_q);
      OP_REM, OP_REMU:               fix_res_d = rneg_q ? -hi_q : hi_q;
      default:                       fix_res_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      out_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (is_multi) begin
              op_q    <= op;
              hi_q    <= '0;
              lo_q    <= a_mag;
              b_q     <= b_mag;
              qneg_q  <= a_neg ^ b_neg;
              rneg_q  <= a_neg;
              dz_q    <= (inp2 == '0);
              cnt_q   <= '0;
              state_q <= EXEC;
            end else begin
              out_q   <= alu_res_d;
              ill_q   <= alu_ill_d;
              state_q <= DONE;
            end
          end
        end
        EXEC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= FIX;
        end
        FIX: begin
          out_q   <= fix_res_d;
          ill_q   <= 1'b0;
          state_q <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against a plain-arithmetic reference model.
module tb_seq_alu;

  localparam int XLEN = 32;
  localparam int TMO  = 100;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] inp1, inp2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out;
  logic            out_illegal;

  int n_cmp = 0;
  int n_bad = 0;

  seq_alu #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .inp1(inp1), .inp2(inp2), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  // Reference: returns {illegal, result}, built from 64-bit arithmetic.
  function automatic logic [32:0] model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] ua, uu, p;
    logic [31:0] r;
    logic il;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    ua = {32'h0, a};
    uu = {32'h0, b};
    r = '0; il = 1'b0; p = '0;
    case (o)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4, 5'd9: r = a << b[4:0];
      5'd5:  r = a >> b[4:0];
      5'd6:  r = a ^ b;
      5'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
      5'd8:  r = (a < b) ? 32'd1 : 32'd0;
      5'd10: r = $signed(a) >>> b[4:0];
      5'd11: begin p = 64'(sa * sb); r = p[31:0]; end
      5'd12: begin p = 64'(sa * sb); r = p[63:32]; end
      5'd13: begin p = 64'(sa * ub); r = p[63:32]; end
      5'd14: begin p = ua * uu; r = p[63:32]; end
      5'd15: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = 64'(sa / sb); r = p[31:0]; end
      end
      5'd16: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd17: begin
        if (b == 0) r = a;
        else begin p = 64'(sa % sb); r = p[31:0]; end
      end
      5'd18: r = (b == 0) ? a : a % b;
      default: il = 1'b1;
    endcase
    return {il, r};
  endfunction

  function automatic int exp_lat(input logic [4:0] o);
    return (o >= 5'd11 && o <= 5'd18) ? XLEN + 1 : 0;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Drives one request and completes its handshake; lat counts edges after accept until out_valid
  // (0 means valid in cycle 1). lat=-1 means out_valid never arrived.
  task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit garbage, output logic [31:0] r, output logic il, output int lat);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
    in_valid = 1'b1; op = o; inp1 = a; inp2 = b;
    @(posedge clk); #1;
    n = 0;
    while (out_valid !== 1'b1 && n < TMO) begin
      if (garbage) begin
        in_valid = 1'($urandom); op = 5'($urandom); inp1 = $urandom; inp2 = $urandom;
      end else in_valid = 1'b0;
      if (n > 0 || out_valid !== 1'b1) begin @(posedge clk); #1; end
      n++;
    end
    lat = (n >= TMO) ? -1 : n;
    r = out; il = out_illegal;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; op = '0; inp1 = '0; inp2 = '0; out_ready = 1'b0;
    #3;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== '0 || out_illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got rdy=%b vld=%b out=%h ill=%b, want rdy=1 vld=0 out=0 ill=0",
               in_ready, out_valid, out, out_illegal);
    end
    $display("reset: rdy=%b vld=%b out=%h ill=%b", in_ready, out_valid, out, out_illegal);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_sub_timing();
    out_ready = 1'b1;
    in_valid = 1'b1; op = 5'd1; inp1 = 32'd5; inp2 = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out !== 32'hFFFF_FFFE || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL sub_cycle1: got vld=%b out=%h rdy=%b, want vld=1 out=fffffffe rdy=0",
               out_valid, out, in_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL sub_cycle2: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    end
    $display("sub 5-7: out=%h", out);
    out_ready = 1'b0;
  endtask

  task automatic test_vectors();
    vec_t vt[$];
    logic [31:0] r;
    logic il;
    int lat;
    vt.push_back('{5'd10, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000});
    vt.push_back('{5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});
    vt.push_back('{5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vt.push_back('{5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    vt.push_back('{5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
    vt.push_back('{5'd16, 32'd7,         32'd0,         32'hFFFF_FFFF});
    vt.push_back('{5'd18, 32'd7,         32'd0,         32'd7});
    vt.push_back('{5'd15, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD});
    vt.push_back('{5'd17, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF});
    vt.push_back('{5'd15, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF});
    foreach (vt[i]) begin
      run_op(vt[i].o, vt[i].a, vt[i].b, 1'b1, r, il, lat);
      n_cmp++;
      if (r !== vt[i].r || il !== 1'b0 || lat != exp_lat(vt[i].o)) begin
        n_bad++;
        $display("FAIL vector_%0d: op=%0d got out=%h ill=%b cycle=%0d, want out=%h ill=0 cycle=%0d",
                 i, vt[i].o, r, il, lat + 1, vt[i].r, exp_lat(vt[i].o) + 1);
      end
      $display("vector op=%0d a=%h b=%h out=%h cycle=%0d", vt[i].o, vt[i].a, vt[i].b, r, lat + 1);
    end
  endtask

  task automatic test_random(input int count);
    logic [4:0] o;
    logic [31:0] a, b, r;
    logic il;
    int lat;
    logic [32:0] m;
    for (int i = 0; i < count; i++) begin
      o = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(19, 31)) : 5'($urandom_range(0, 18));
      a = pick_operand();
      b = pick_operand();
      m = model(o, a, b);
      run_op(o, a, b, 1'b1, r, il, lat);
      n_cmp++;
      if (r !== m[31:0]) begin
        n_bad++;
        $display("FAIL rand_result: op=%0d a=%h b=%h got %h want %h", o, a, b, r, m[31:0]);
      end
      n_cmp++;
      if (il !== m[32]) begin
        n_bad++;
        $display("FAIL rand_illegal: op=%0d got %b want %b", o, il, m[32]);
      end
      n_cmp++;
      if (lat != exp_lat(o)) begin
        n_bad++;
        $display("FAIL rand_latency: op=%0d got cycle %0d want cycle %0d", o, lat + 1, exp_lat(o) + 1);
      end
      $display("rand op=%0d a=%h b=%h out=%h ill=%b cycle=%0d", o, a, b, r, il, lat + 1);
    end
  endtask

  task automatic test_hold();
    int n;
    logic [31:0] r;
    logic il;
    int lat;
    in_valid = 1'b1; op = 5'd15; inp1 = 32'hFFFF_FFF9; inp2 = 32'd2;
    @(posedge clk); #1;
    n = 0;
    while (out_valid !== 1'b1 && n < TMO) begin
      in_valid = 1'b1; op = 5'd0; inp1 = $urandom; inp2 = $urandom;
      @(posedge clk); #1; n++;
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; op = 5'd0;
      n_cmp++;
      if (out_valid !== 1'b1 || out !== 32'hFFFF_FFFD || in_ready !== 1'b0 || out_illegal !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_%0d: got vld=%b out=%h rdy=%b ill=%b, want vld=1 out=fffffffd rdy=0 ill=0",
                 c, out_valid, out, in_ready, out_illegal);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    end
    $display("hold div -7/2: out=%h", out);
    run_op(5'd17, 32'hFFFF_FFF9, 32'd2, 1'b0, r, il, lat);
    n_cmp++;
    if (r !== 32'hFFFF_FFFF || lat != XLEN + 1) begin
      n_bad++;
      $display("FAIL rem_after_hold: got %h cycle %0d, want ffffffff cycle %0d", r, lat + 1, XLEN + 2);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic il;
    int lat;
    bit seen;
    in_valid = 1'b1; op = 5'd16; inp1 = 32'd1000; inp2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_before_reset: got rdy=%b want 0", in_ready);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== '0 || out_illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_exec: got vld=%b rdy=%b out=%h ill=%b, want vld=0 rdy=1 out=0 ill=0",
               out_valid, in_ready, out, out_illegal);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < XLEN + 6; c++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL no_result_after_reset: got out_valid=1 want 0");
    end
    run_op(5'd0, 32'd1, 32'd1, 1'b0, r, il, lat);
    n_cmp++;
    if (r !== 32'd2 || il !== 1'b0 || lat != 0) begin
      n_bad++;
      $display("FAIL add_after_reset: got %h ill=%b cycle=%0d, want 2 ill=0 cycle=1", r, il, lat + 1);
    end
    run_op(5'd25, $urandom, $urandom, 1'b0, r, il, lat);
    n_cmp++;
    if (r !== 32'd0 || il !== 1'b1 || lat != 0) begin
      n_bad++;
      $display("FAIL illegal_op: got %h ill=%b cycle=%0d, want 0 ill=1 cycle=1", r, il, lat + 1);
    end
    $display("reset mid-divu then add/illegal done");
  endtask

  initial begin
    test_reset();
    test_sub_timing();
    test_vectors();
    test_random(220);
    test_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
